// File: rtl/tensor_core_scheduler.sv
// rtl/tensor_core_scheduler.sv - single-job TensorCore tile sequencer with per-phase watchdog
//
// Ports:
//   clk, rstn                  clock, synchronous reset (rstn=1 resets)
//   job_valid/job_id/job_ready job intake handshake
//   mem_req/mem_sel/mem_beat   operand beat request (sel 0=A, 1=B, 2=C), mem_ack completes a beat
//   tc_start, tc_fetch_done    one-cycle control pulses to the TensorCore
//   tc_idle/fetch/compute/write_back  TensorCore status inputs
//   res_valid/res_beat/res_id  result write-back beat capture
//   done, busy                 job-complete pulse, scheduler-active flag
//   err/err_code/clr_err       sticky error (1=timeout, 2=short write-back, 3=unexpected idle)
module tensor_core_scheduler #(
  parameter int A_BEATS = 2,
  parameter int B_BEATS = 4,
  parameter int C_BEATS = 8,
  parameter int BEAT_W  = 3,
  parameter int ID_W    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              job_valid,
  input  logic [ID_W-1:0]   job_id,
  output logic              job_ready,
  output logic              mem_req,
  output logic [1:0]        mem_sel,
  output logic [BEAT_W-1:0] mem_beat,
  input  logic              mem_ack,
  output logic              tc_start,
  output logic              tc_fetch_done,
  input  logic              tc_idle,
  input  logic              tc_fetch,
  input  logic              tc_compute,
  input  logic              tc_write_back,
  output logic              res_valid,
  output logic [BEAT_W-1:0] res_beat,
  output logic [ID_W-1:0]   res_id,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              clr_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT_FETCH, S_FETCH, S_FDONE,
    S_WAIT_WB, S_WB, S_WAIT_IDLE, S_ERROR
  } state_t;

  localparam logic [15:0]       WD_LAST = 16'(TIMEOUT - 1);
  localparam logic [BEAT_W-1:0] A_LAST  = BEAT_W'(A_BEATS - 1);
  localparam logic [BEAT_W-1:0] B_LAST  = BEAT_W'(B_BEATS - 1);
  localparam logic [BEAT_W-1:0] C_LAST  = BEAT_W'(C_BEATS - 1);

  state_t            state_q;
  logic [1:0]        sel_q;
  logic [BEAT_W-1:0] beat_q;
  logic [15:0]       wd_q;
  logic [ID_W-1:0]   res_id_q;
  logic [1:0]        err_code_q;
  logic              job_ready_q;
  logic              mem_req_q;
  logic              tc_start_q;
  logic              fetch_done_q;
  logic              res_valid_q;
  logic              done_q;
  logic              busy_q;
  logic              err_q;

  logic              fault_d;
  logic [1:0]        fault_code_d;

  // Compute phase progress is observed only; no decision depends on it.
  logic unused_compute;
  assign unused_compute = tc_compute;

  // Fault detection; timeout outranks unexpected idle, which outranks a short write-back.
  always_comb begin
    fault_d      = 1'b0;
    fault_code_d = 2'd0;
    if (state_q != S_IDLE && state_q != S_ERROR && wd_q == WD_LAST) begin
      fault_d      = 1'b1;
      fault_code_d = 2'd1;
    end else if (tc_idle && (state_q inside {S_WAIT_FETCH, S_FETCH, S_FDONE, S_WAIT_WB})) begin
      fault_d      = 1'b1;
      fault_code_d = 2'd3;
    end else if (state_q == S_WB && !tc_write_back && beat_q != C_LAST) begin
      fault_d      = 1'b1;
      fault_code_d = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q      <= S_IDLE;
      sel_q        <= 2'd0;
      beat_q       <= '0;
      wd_q         <= 16'd0;
      res_id_q     <= '0;
      err_code_q   <= 2'd0;
      job_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      tc_start_q   <= 1'b0;
      fetch_done_q <= 1'b0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      tc_start_q   <= 1'b0;
      fetch_done_q <= 1'b0;
      done_q       <= 1'b0;
      // Watchdog runs only while a job is in flight; each delivered beat restarts it.
      if (mem_ack || state_q == S_IDLE || state_q == S_ERROR) wd_q <= 16'd0;
      else                                                     wd_q <= wd_q + 16'd1;

      if (fault_d) begin
        state_q     <= S_ERROR;
        wd_q        <= 16'd0;
        err_q       <= 1'b1;
        err_code_q  <= fault_code_d;
        mem_req_q   <= 1'b0;
        res_valid_q <= 1'b0;
        job_ready_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (job_valid && job_ready_q) begin
              state_q     <= S_START;
              res_id_q    <= job_id;
              tc_start_q  <= 1'b1;
              busy_q      <= 1'b1;
              job_ready_q <= 1'b0;
            end else begin
              job_ready_q <= tc_idle;
            end
          end
          S_START: begin
            state_q <= S_WAIT_FETCH;
            wd_q    <= 16'd0;
          end
          S_WAIT_FETCH: begin
            if (tc_fetch) begin
              state_q   <= S_FETCH;
              wd_q      <= 16'd0;
              sel_q     <= 2'd0;
              beat_q    <= '0;
              mem_req_q <= 1'b1;
            end
          end
          S_FETCH: begin
            // sel/beat only move on an ack, so the request stays stable across stalls.
            if (mem_ack) begin
              if (sel_q == 2'd0 && beat_q == A_LAST) begin
                sel_q  <= 2'd1;
                beat_q <= '0;
              end else if (sel_q == 2'd1 && beat_q == B_LAST) begin
                sel_q  <= 2'd2;
                beat_q <= '0;
              end else if (sel_q == 2'd2 && beat_q == C_LAST) begin
                state_q      <= S_FDONE;
                wd_q         <= 16'd0;
                mem_req_q    <= 1'b0;
                fetch_done_q <= 1'b1;
                sel_q        <= 2'd0;
                beat_q       <= '0;
              end else begin
                beat_q <= beat_q + 1'b1;
              end
            end
          end
          S_FDONE: begin
            state_q <= S_WAIT_WB;
            wd_q    <= 16'd0;
          end
          S_WAIT_WB: begin
            // The first write-back beat is the cycle tc_write_back rises; it shows up as beat 0.
            if (tc_write_back) begin
              state_q     <= S_WB;
              wd_q        <= 16'd0;
              beat_q      <= '0;
              res_valid_q <= 1'b1;
            end
          end
          S_WB: begin
            if (beat_q == C_LAST) begin
              state_q     <= S_WAIT_IDLE;
              wd_q        <= 16'd0;
              beat_q      <= '0;
              res_valid_q <= 1'b0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
          S_WAIT_IDLE: begin
            // job_ready stays low during the done cycle so the next accept lands one cycle later.
            if (tc_idle) begin
              state_q     <= S_IDLE;
              wd_q        <= 16'd0;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              job_ready_q <= 1'b0;
            end
          end
          S_ERROR: begin
            if (clr_err) begin
              state_q     <= S_IDLE;
              err_q       <= 1'b0;
              err_code_q  <= 2'd0;
              busy_q      <= 1'b0;
              job_ready_q <= tc_idle;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign job_ready     = job_ready_q;
  assign mem_req       = mem_req_q;
  assign mem_sel       = mem_req_q ? sel_q : 2'd0;
  assign mem_beat      = mem_req_q ? beat_q : '0;
  assign tc_start      = tc_start_q;
  assign tc_fetch_done = fetch_done_q;
  assign res_valid     = res_valid_q;
  assign res_beat      = res_valid_q ? beat_q : '0;
  assign res_id        = res_id_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// tb/tb_tensor_core_scheduler.sv - directed self-checking bench for tensor_core_scheduler
module tb_tensor_core_scheduler;

  logic       clk = 1'b0;
  logic       rstn, job_valid, job_ready, mem_req, mem_ack;
  logic [7:0] job_id, res_id;
  logic [1:0] mem_sel, err_code;
  logic [2:0] mem_beat, res_beat;
  logic       tc_start, tc_fetch_done, tc_idle, tc_fetch, tc_compute, tc_write_back;
  logic       res_valid, done, busy, err, clr_err;

  int tests = 0;
  int fails = 0;
  int n_start = 0, n_fdone = 0, n_done = 0, n_overlap = 0;
  int snap_fdone;

  always #5 clk = ~clk;

  tensor_core_scheduler #(
    .A_BEATS(2), .B_BEATS(4), .C_BEATS(8), .BEAT_W(3), .ID_W(8), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rstn(rstn), .job_valid(job_valid), .job_id(job_id), .job_ready(job_ready),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_beat(mem_beat), .mem_ack(mem_ack),
    .tc_start(tc_start), .tc_fetch_done(tc_fetch_done), .tc_idle(tc_idle), .tc_fetch(tc_fetch),
    .tc_compute(tc_compute), .tc_write_back(tc_write_back), .res_valid(res_valid),
    .res_beat(res_beat), .res_id(res_id), .done(done), .busy(busy), .err(err),
    .err_code(err_code), .clr_err(clr_err)
  );

  always @(negedge clk) begin
    if (tc_start)         n_start++;
    if (tc_fetch_done)    n_fdone++;
    if (done)             n_done++;
    if (tc_start && done) n_overlap++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {sel, beat} for the k-th fetch beat: A0-1, B0-3, C0-7.
  function automatic logic [4:0] fexp(input int k);
    if (k < 2)      return {2'd0, 3'(k)};
    else if (k < 6) return {2'd1, 3'(k - 2)};
    else            return {2'd2, 3'(k - 6)};
  endfunction

  // Drives one complete job from the START cycle through the done pulse.
  task automatic run_body(input logic [7:0] id);
    tc_idle = 1'b0; tick;
    tc_fetch = 1'b1; tick;
    tc_fetch = 1'b0; mem_ack = 1'b1;
    repeat (14) tick;
    mem_ack = 1'b0;
    chk("body_fetch_done", tc_fetch_done, 1'b1);
    tick;
    tc_write_back = 1'b1;
    repeat (8) tick;
    tc_write_back = 1'b0;
    chk("body_last_beat", {res_valid, res_beat, res_id}, {1'b1, 3'd7, id});
    tick;
    tc_idle = 1'b1; tick;
    chk("body_done", done, 1'b1);
  endtask

  initial begin
    int k;
    int cyc;
    rstn = 1'b1; job_valid = 1'b0; job_id = 8'h00; mem_ack = 1'b0; tc_idle = 1'b1;
    tc_fetch = 1'b0; tc_compute = 1'b0; tc_write_back = 1'b0; clr_err = 1'b0;
    repeat (3) tick;

    // Reset state
    chk("rst_outputs",
        {job_ready, mem_req, mem_sel, mem_beat, tc_start, tc_fetch_done, res_valid, res_beat, done, busy, err, err_code},
        {1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0});
    chk("rst_res_id", res_id, 8'h00);
    rstn = 1'b0; tick;
    chk("idle_ready", job_ready, 1'b1);

    // Nominal job 0x5A
    job_valid = 1'b1; job_id = 8'h5A; tick;
    chk("t1_start", {tc_start, job_ready, busy, res_id}, {1'b1, 1'b0, 1'b1, 8'h5A});
    job_valid = 1'b0; tc_idle = 1'b0; tick;
    chk("t1_start_once", {tc_start, mem_req}, 2'b00);
    tc_fetch = 1'b1; tick;
    tc_fetch = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 14; i++) begin
      chk("t1_fetch_beat", {mem_req, mem_sel, mem_beat}, {1'b1, fexp(i)});
      tick;
    end
    mem_ack = 1'b0;
    chk("t1_fdone", {tc_fetch_done, mem_req}, 2'b10);
    tick;
    chk("t1_fdone_once", tc_fetch_done, 1'b0);
    tc_compute = 1'b1; tick;
    chk("t1_wait_wb", {res_valid, busy, err}, 3'b010);
    tc_compute = 1'b0; tc_write_back = 1'b1; tick;
    for (int j = 0; j < 8; j++) begin
      chk("t1_res_beat", {res_valid, res_beat, res_id}, {1'b1, 3'(j), 8'h5A});
      if (j == 7) tc_write_back = 1'b0;
      tick;
    end
    chk("t1_wb_end", {res_valid, done, busy}, 3'b001);
    tc_idle = 1'b1; tick;
    chk("t1_done", {done, busy, job_ready}, 3'b100);
    tick;
    chk("t1_after_done", {done, busy, job_ready}, 3'b001);
    chk("t1_pulse_counts", {n_start[7:0], n_fdone[7:0], n_done[7:0]}, {8'd1, 8'd1, 8'd1});

    // Ack stalls: one ack every third cycle
    job_valid = 1'b1; job_id = 8'h11; tick;
    chk("t2_start", tc_start, 1'b1);
    job_valid = 1'b0; tc_idle = 1'b0; tick;
    tc_fetch = 1'b1; tick;
    tc_fetch = 1'b0;
    k = 0; cyc = 0;
    while (k < 14 && cyc < 100) begin
      chk("t2_stall_beat", {mem_req, mem_sel, mem_beat}, {1'b1, fexp(k)});
      mem_ack = (cyc % 3 == 2);
      tick;
      if (mem_ack) k++;
      cyc++;
    end
    mem_ack = 1'b0;
    chk("t2_beats_in_budget", k, 14);
    chk("t2_fdone", {tc_fetch_done, err}, 2'b10);

    // Short write-back: 5 beats only
    tick;
    tc_write_back = 1'b1; tick;
    for (int j = 0; j < 5; j++) begin
      chk("t3_res_beat", {res_valid, res_beat}, {1'b1, 3'(j)});
      if (j == 4) tc_write_back = 1'b0;
      tick;
    end
    chk("t3_err", {err, err_code, res_valid, job_ready, mem_req}, {1'b1, 2'd2, 1'b0, 1'b0, 1'b0});
    job_valid = 1'b1; job_id = 8'h99; tc_idle = 1'b1; tick;
    chk("t3_no_accept_in_err", {tc_start, busy, err, err_code}, {1'b0, 1'b1, 1'b1, 2'd2});
    job_valid = 1'b0; clr_err = 1'b1; tick;
    clr_err = 1'b0;
    chk("t3_clr", {err, err_code, busy, job_ready}, {1'b0, 2'd0, 1'b0, 1'b1});

    // Timeout in WAIT_FETCH
    job_valid = 1'b1; job_id = 8'h22; tick;
    job_valid = 1'b0; tc_idle = 1'b0; tick;
    for (int i = 1; i < 64; i++) begin
      tick;
      chk("t4_no_err_no_req", {err, mem_req}, 2'b00);
    end
    tick;
    chk("t4_timeout", {err, err_code, mem_req}, {1'b1, 2'd1, 1'b0});
    tc_idle = 1'b1; clr_err = 1'b1; tick;
    clr_err = 1'b0;
    chk("t4_clr", {err, job_ready}, 2'b01);

    // Reset mid-fetch after 3 acks
    job_valid = 1'b1; job_id = 8'h33; tick;
    job_valid = 1'b0; tc_idle = 1'b0; tick;
    tc_fetch = 1'b1; tick;
    tc_fetch = 1'b0; mem_ack = 1'b1;
    repeat (3) tick;
    chk("t5_pre_reset_beat", {mem_req, mem_sel, mem_beat}, {1'b1, fexp(3)});
    snap_fdone = n_fdone;
    rstn = 1'b1; mem_ack = 1'b0; tick;
    chk("t5_reset_outputs",
        {job_ready, mem_req, mem_sel, mem_beat, tc_start, tc_fetch_done, res_valid, done, busy, err, err_code},
        {1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
    chk("t5_reset_res_id", res_id, 8'h00);
    repeat (3) tick;
    rstn = 1'b0; tc_idle = 1'b1; tick;
    chk("t5_no_fetch_done", n_fdone - snap_fdone, 0);
    job_valid = 1'b1; job_id = 8'h44; tick;
    job_valid = 1'b0; tc_idle = 1'b0; tick;
    tc_fetch = 1'b1; tick;
    tc_fetch = 1'b0;
    chk("t5_restart_a0", {mem_req, mem_sel, mem_beat, res_id}, {1'b1, 2'd0, 3'd0, 8'h44});
    rstn = 1'b1; tick;
    rstn = 1'b0; tc_idle = 1'b1; tick;

    // Back-to-back jobs with job_valid held
    job_valid = 1'b1; job_id = 8'hA1; tick;
    chk("t6_first_start", {tc_start, res_id}, {1'b1, 8'hA1});
    job_id = 8'hB2;
    run_body(8'hA1);
    chk("t6_done_cycle", {done, tc_start, job_ready, busy}, 4'b1000);
    tick;
    chk("t6_after_done", {job_ready, tc_start, done}, 3'b100);
    tick;
    chk("t6_second_start", {tc_start, res_id}, {1'b1, 8'hB2});
    job_valid = 1'b0;
    run_body(8'hB2);
    tick;
    chk("t6_final_idle", {busy, done, err}, 3'b000);
    chk("t6_no_overlap", n_overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
